// File: rtl/ltm_serial_bus_arbiter_pkg.sv
// Shared encodings for the LTM serial bus arbiter: FSM states and bus owner codes.
package ltm_serial_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLcdOwn = 2'b01,
        StAdcOwn = 2'b10,
        StGuard  = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnerNone = 2'b00,
        OwnerLcd  = 2'b01,
        OwnerAdc  = 2'b10
    } owner_e;

endpackage

// File: rtl/ltm_bus_pin_mux.sv
// Registered pin mux: drives the shared serial clock and gated selects from the
// owner that will hold the bus after this edge.
module ltm_bus_pin_mux
    import ltm_serial_bus_arbiter_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  owner_e owner_i,
    input  logic   lcd_sclk_i,
    input  logic   lcd_scen_i,
    input  logic   adc_dclk_i,
    input  logic   adc_cs_n_i,
    output logic   sclk_o,
    output logic   lcd_scen_o,
    output logic   adc_cs_n_o
);

    logic sclk_d, lcd_scen_d, adc_cs_n_d;
    logic sclk_q, lcd_scen_q, adc_cs_n_q;

    always_comb begin
        sclk_d     = 1'b0;
        lcd_scen_d = 1'b1;
        adc_cs_n_d = 1'b1;
        unique case (owner_i)
            OwnerLcd: begin
                sclk_d     = lcd_sclk_i;
                lcd_scen_d = lcd_scen_i;
            end
            OwnerAdc: begin
                sclk_d     = adc_dclk_i;
                adc_cs_n_d = adc_cs_n_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_q     <= 1'b0;
            lcd_scen_q <= 1'b1;
            adc_cs_n_q <= 1'b1;
        end else begin
            sclk_q     <= sclk_d;
            lcd_scen_q <= lcd_scen_d;
            adc_cs_n_q <= adc_cs_n_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign lcd_scen_o = lcd_scen_q;
    assign adc_cs_n_o = adc_cs_n_q;

endmodule

// File: rtl/ltm_serial_bus_arbiter.sv
// Arbitrates the LTM shared serial clock between the LCD config and touch ADC
// controllers: round-robin grant, guard gap between owners, forced release on overhold.
module ltm_serial_bus_arbiter
    import ltm_serial_bus_arbiter_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned MAX_HOLD     = 65535,
    parameter int unsigned HOLD_W       = 16
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iLCD_REQ,
    output logic       oLCD_GNT,
    input  logic       iLCD_SCLK,
    input  logic       iLCD_SCEN,
    input  logic       iADC_REQ,
    output logic       oADC_GNT,
    input  logic       iADC_DCLK,
    input  logic       iADC_CS_n,
    output logic       oSCLK,
    output logic       oLCD_SCEN,
    output logic       oADC_CS_n,
    output logic [1:0] oOWNER,
    output logic       oTIMEOUT
);

    localparam logic [HOLD_W-1:0] HoldLast  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [7:0]        GuardLast = 8'(GUARD_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        guard_q, guard_d;
    logic              last_adc_q, last_adc_d;
    logic              lcd_armed_q, lcd_armed_d;
    logic              adc_armed_q, adc_armed_d;
    logic              timeout_q, timeout_d;
    logic              lcd_gnt_q, adc_gnt_q;
    owner_e            owner_q, owner_d;
    logic              lcd_elig, adc_elig;

    assign lcd_elig = iLCD_REQ & lcd_armed_q;
    assign adc_elig = iADC_REQ & adc_armed_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        guard_d    = guard_q;
        last_adc_d = last_adc_q;
        timeout_d  = 1'b0;
        // A requester re-arms once its REQ has been seen low for a cycle.
        lcd_armed_d = lcd_armed_q | ~iLCD_REQ;
        adc_armed_d = adc_armed_q | ~iADC_REQ;

        unique case (state_q)
            StIdle: begin
                hold_d = '0;
                if (lcd_elig && (!adc_elig || last_adc_q)) begin
                    state_d    = StLcdOwn;
                    last_adc_d = 1'b0;
                end else if (adc_elig) begin
                    state_d    = StAdcOwn;
                    last_adc_d = 1'b1;
                end
            end
            StLcdOwn: begin
                if (!iLCD_REQ) begin
                    state_d = StGuard;
                    hold_d  = '0;
                end else if (hold_q == HoldLast) begin
                    state_d     = StGuard;
                    hold_d      = '0;
                    timeout_d   = 1'b1;
                    lcd_armed_d = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StAdcOwn: begin
                if (!iADC_REQ) begin
                    state_d = StGuard;
                    hold_d  = '0;
                end else if (hold_q == HoldLast) begin
                    state_d     = StGuard;
                    hold_d      = '0;
                    timeout_d   = 1'b1;
                    adc_armed_d = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StGuard: begin
                if (guard_q == GuardLast) begin
                    state_d = StIdle;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so grant and pins change together.
    always_comb begin
        owner_d = OwnerNone;
        unique case (state_d)
            StLcdOwn: owner_d = OwnerLcd;
            StAdcOwn: owner_d = OwnerAdc;
            default:  owner_d = OwnerNone;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            guard_q     <= '0;
            last_adc_q  <= 1'b1;
            lcd_armed_q <= 1'b1;
            adc_armed_q <= 1'b1;
            timeout_q   <= 1'b0;
            lcd_gnt_q   <= 1'b0;
            adc_gnt_q   <= 1'b0;
            owner_q     <= OwnerNone;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            guard_q     <= guard_d;
            last_adc_q  <= last_adc_d;
            lcd_armed_q <= lcd_armed_d;
            adc_armed_q <= adc_armed_d;
            timeout_q   <= timeout_d;
            lcd_gnt_q   <= (owner_d == OwnerLcd);
            adc_gnt_q   <= (owner_d == OwnerAdc);
            owner_q     <= owner_d;
        end
    end

    ltm_bus_pin_mux u_pin_mux (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .owner_i    (owner_d),
        .lcd_sclk_i (iLCD_SCLK),
        .lcd_scen_i (iLCD_SCEN),
        .adc_dclk_i (iADC_DCLK),
        .adc_cs_n_i (iADC_CS_n),
        .sclk_o     (oSCLK),
        .lcd_scen_o (oLCD_SCEN),
        .adc_cs_n_o (oADC_CS_n)
    );

    assign oLCD_GNT = lcd_gnt_q;
    assign oADC_GNT = adc_gnt_q;
    assign oOWNER   = owner_q;
    assign oTIMEOUT = timeout_q;

endmodule

// File: doc/ltm_serial_bus_arbiter.md
# ltm_serial_bus_arbiter

Arbitrates the single shared serial clock line to the LTM panel between the LCD 3-wire configuration controller and the touch-screen ADC SPI controller. It sits between those two controllers and the GPIO pins, and replaces the ad-hoc busy-flag clock gating. It grants ownership by request/grant handshake, inserts a guard gap between owners, and forces a release if an owner holds the bus too long.

## Interface
Parameters:
- GUARD_CYCLES, 4, idle iCLK cycles between release and the next grant; legal range 1..255
- MAX_HOLD, 65535, maximum iCLK cycles one owner may hold the bus; legal range 2..65535
- HOLD_W, 16, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
- iCLK  in  1  system clock (50 MHz domain)
- iRST  in  1  reset, asynchronous, active-high
- iLCD_REQ  in  1  LCD controller requests the bus
- oLCD_GNT  out  1  LCD controller owns the bus
- iLCD_SCLK  in  1  LCD 3-wire serial clock
- iLCD_SCEN  in  1  LCD 3-wire enable, active-low
- iADC_REQ  in  1  ADC controller requests the bus
- oADC_GNT  out  1  ADC controller owns the bus
- iADC_DCLK  in  1  ADC serial clock
- iADC_CS_n  in  1  ADC chip select, active-low
- oSCLK  out  1  shared serial clock pin
- oLCD_SCEN  out  1  gated LCD enable pin, active-low
- oADC_CS_n  out  1  gated ADC chip select pin, active-low
- oOWNER  out  2  current owner: 00 none, 01 LCD, 10 ADC
- oTIMEOUT  out  1  one-cycle pulse on a forced release

## Operation
- States: IDLE, LCD_OWN, ADC_OWN, GUARD.
- Request selection in IDLE:
  - One eligible request: grant it.
  - Both eligible: grant the requester that was not the last owner (round-robin).
  - last_owner resets to ADC, so the LCD wins the first contention after reset.
- In LCD_OWN or ADC_OWN:
  - GNT is high for that owner only.
  - oSCLK = owner's clock; the owner's select is passed through.
  - The non-owner's select is held deasserted (1).
- Normal release: the owner drops REQ. GNT falls, outputs return to idle values, and the state moves to GUARD.
- Forced release:
  - The hold counter counts cycles in an OWN state.
  - When it reaches MAX_HOLD-1, the arbiter releases as above and pulses oTIMEOUT.
  - The evicted requester becomes ineligible until its REQ has been low for at least one cycle (re-arm flag).
- GUARD: counts GUARD_CYCLES cycles, then goes to IDLE. Requests are ignored during GUARD.
- Idle output values: oSCLK=0, oLCD_SCEN=1, oADC_CS_n=1, both GNT=0, oOWNER=00.
- A requester's REQ asserted while the other owns the bus stays pending. No preemption except timeout.

## Timing
- All outputs are registered.
- Reset: every output asynchronously goes to its idle value, oTIMEOUT=0. State=IDLE, counters=0, re-arm flags set.
- Grant latency: REQ high at edge n (state IDLE) gives GNT high after edge n+1.
- Pin pass-through latency: owner SCLK/select are sampled each iCLK and appear on the pins one cycle later. Owner serial clocks must be at most iCLK/2.
- Release: REQ low at edge n gives GNT low and pins idle after edge n+1. GUARD then lasts GUARD_CYCLES cycles, so the earliest new GNT comes GUARD_CYCLES+1 cycles after the release edge.
- Timeout: GNT falls on the same edge that oTIMEOUT rises. oTIMEOUT is high exactly one cycle.
- Simultaneous REQ edges in IDLE resolve by last_owner in the same cycle.
- Reset mid-transfer aborts immediately; pins go idle without waiting for GUARD.

## Structure
- Shared package holds the state encoding (IDLE/LCD_OWN/ADC_OWN/GUARD) and the owner codes 00/01/10.
- One natural sub-module: ltm_bus_pin_mux, a registered output mux selecting SCLK/selects by owner code.
- FSM, counters and re-arm flags stay in the top of the block.

## Test plan
- Reset release, LCD_REQ=1 alone → oLCD_GNT=1 and oOWNER=01 one cycle later. oSCLK tracks iLCD_SCLK delayed by 1 cycle; oADC_CS_n=1 throughout.
- Both REQ rise the same cycle after reset → LCD granted first. After LCD release plus 4 guard cycles, ADC is granted; LCD re-requesting meanwhile waits.
- ADC owns the bus with 3 LCD_SCLK toggles injected → oSCLK follows only iADC_DCLK and oLCD_SCEN stays 1.
- MAX_HOLD=16, ADC holds REQ → GNT drops after 16 owned cycles with a 1-cycle oTIMEOUT. ADC is not regranted until its REQ goes low then high; LCD is granted after the guard if requesting.
- GUARD_CYCLES=1, release then immediate re-request → new GNT exactly 2 cycles after the release edge.
- iRST asserted mid-LCD transfer → all outputs idle asynchronously. After deassert, state is IDLE and the next REQ is granted in 1 cycle.
